pulse_burst_sched: RTL and testbench

- Shares one period counter/compare pulse engine between two requesters.
- Each requester asks for a burst of N pulses at a programmable period.
- Round-robin arbitration picks the requester; the block sequences the burst, then reports completion.
- Sits between software-configurable pulse clients and the downstream pulse consumer; pulse spacing matches the existing compare-reset convention (compare value P gives one pulse every P+1 cycles).

---
 rtl/pulse_burst_sched_pkg.sv | 19 +
 rtl/pulse_burst_sched_period_counter.sv | 35 +++
 rtl/pulse_burst_sched.sv | 132 +++++++++++++
 tb/tb_pulse_burst_sched.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_burst_sched_pkg.sv
// pulse_burst_sched_pkg
//   Shared definitions for the two-requester pulse burst scheduler:
//   FSM state encoding, requester count and a small one-hot helper.
package pulse_burst_sched_pkg;

    localparam int NREQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One-hot grant/done vector for a requester index.
    function automatic logic [NREQ-1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/pulse_burst_sched_period_counter.sv
// period_counter
//   Free-running up-counter with a synchronous clear and an equality compare.
//   With clr driven by its own hit, a compare value P produces one hit every
//   P+1 enabled cycles.
// Ports:
//   clk      rising-edge clock
//   clr      synchronous clear (highest priority)
//   en       count enable
//   cmp_val  compare value
//   cnt_val  current count
//   hit      cnt_val == cmp_val
module period_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] cmp_val,
    output logic [CNT_W-1:0] cnt_val,
    output logic             hit
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_val <= '0;
        end else if (en) begin
            cnt_val <= cnt_val + ONE;
        end
    end

    assign hit = (cnt_val == cmp_val);

endmodule

// File: rtl/pulse_burst_sched.sv
// pulse_burst_sched
//   Shares one period counter between two requesters. A request sampled in
//   IDLE is arbitrated round-robin, the winner's period P and count N are
//   latched, and N pulses are issued, one every P+1 cycles. A single DONE
//   cycle then strobes done[] for the owner before returning to IDLE.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | waiting for req; arbitrates and latches P/N of the winner
//   RUN     | engine counting; pulse on compare hit, remaining decrements
//   DONE    | single-cycle completion strobe, pointer moves to the owner
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   req[1:0]          burst request levels, sampled only in IDLE
//   period0/count0    requester 0 compare value and pulse count
//   period1/count1    requester 1 compare value and pulse count
//   abort             ends the active burst (RUN only)
//   grant[1:0]        one-hot owner, first RUN cycle through DONE
//   busy              high in RUN and DONE
//   pulse             single-cycle output pulse
//   done[1:0]         one-cycle completion strobe for the owner
module pulse_burst_sched
    import pulse_burst_sched_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic [CNT_W-1:0] period0,
    input  logic [CNT_W-1:0] count0,
    input  logic [CNT_W-1:0] period1,
    input  logic [CNT_W-1:0] count1,
    input  logic             abort,
    output logic [NREQ-1:0]  grant,
    output logic             busy,
    output logic             pulse,
    output logic [NREQ-1:0]  done
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic             owner;
    logic             last;
    logic [CNT_W-1:0] per_l;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] cnt;
    logic             hit;
    logic             load;
    logic             win;
    logic [CNT_W-1:0] win_period;
    logic [CNT_W-1:0] win_count;

    // A tie goes to whoever was not served last; last resets to 1 so
    // requester 0 wins the first tie.
    assign win        = (req == 2'b11) ? ~last : req[1];
    assign win_period = win ? period1 : period0;
    assign win_count  = win ? count1  : count0;
    assign load       = (state == ST_IDLE) && (req != '0);

    period_counter #(
        .CNT_W (CNT_W)
    ) u_period_counter (
        .clk     (clk),
        .clr     (reset | hit | load),
        .en      (state == ST_RUN),
        .cmp_val (per_l),
        .cnt_val (cnt),
        .hit     (hit)
    );

    // Decoded from the state register and the counter/compare registers,
    // so the pulse lines up with cnt == P_l without an input path.
    assign pulse = (state == ST_RUN) && hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            per_l     <= '0;
            remaining <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            done      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        owner     <= win;
                        per_l     <= win_period;
                        remaining <= win_count;
                        grant     <= req_onehot(win);
                        busy      <= 1'b1;
                        if (win_count != '0) begin
                            state <= ST_RUN;
                        end else begin
                            state <= ST_DONE;
                            done  <= req_onehot(win);
                        end
                    end
                end
                ST_RUN: begin
                    if (pulse) begin
                        remaining <= remaining - ONE;
                    end
                    // The pulse of an aborted cycle still goes out; nothing after.
                    if (abort || (pulse && remaining == ONE)) begin
                        state <= ST_DONE;
                        done  <= req_onehot(owner);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    last  <= owner;
                    grant <= '0;
                    busy  <= 1'b0;
                    done  <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                    done  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_burst_sched.sv
// tb_pulse_burst_sched
//   Table-driven burst vectors, hand-written corner sequences and random
//   stimulus, with a per-cycle transaction-level reference model.
module tb_pulse_burst_sched;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       req = 2'b00;
    logic [CNT_W-1:0] period0 = '0;
    logic [CNT_W-1:0] count0 = '0;
    logic [CNT_W-1:0] period1 = '0;
    logic [CNT_W-1:0] count1 = '0;
    logic             abort = 1'b0;
    logic [1:0]       grant;
    logic             busy;
    logic             pulse;
    logic [1:0]       done;

    int vectors = 0;
    int miscompares = 0;

    pulse_burst_sched #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .period0 (period0),
        .count0  (count0),
        .period1 (period1),
        .count1  (count1),
        .abort   (abort),
        .grant   (grant),
        .busy    (busy),
        .pulse   (pulse),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Reference model: a burst is described by its owner, sample cycle T,
    // period P and completion cycle. Pulses fall at T+k(P+1) before the
    // completion cycle; abort in a RUN cycle moves completion to the next cycle.
    bit mon_on = 1'b0;
    bit m_active = 1'b0;
    bit m_w = 1'b0;
    bit m_last = 1'b1;
    int m_t = 0;
    int m_p = 0;
    int m_done_cyc = 0;
    int cyc = 0;

    always @(negedge clk) begin : monitor
        logic [1:0] eg, ed;
        logic       eb, ep;
        if (mon_on) begin
            eg = 2'b00; ed = 2'b00; eb = 1'b0; ep = 1'b0;
            if (m_active) begin
                eg = m_w ? 2'b10 : 2'b01;
                eb = 1'b1;
                if (cyc == m_done_cyc) ed = eg;
                else if (((cyc - m_t) % (m_p + 1)) == 0) ep = 1'b1;
            end
            vectors++;
            if ({grant, busy, pulse, done} !== {eg, eb, ep, ed}) begin
                miscompares++;
                $display("FAIL cycle_check cyc=%0d got g=%b b=%b p=%b d=%b want g=%b b=%b p=%b d=%b",
                         cyc, grant, busy, pulse, done, eg, eb, ep, ed);
            end
            if (reset) begin
                m_active = 1'b0;
                m_last   = 1'b1;
            end else if (m_active) begin
                if (cyc == m_done_cyc) begin
                    m_active = 1'b0;
                    m_last   = m_w;
                end else if (abort) begin
                    m_done_cyc = cyc + 1;
                end
            end else if (req != 2'b00) begin
                m_w        = (req == 2'b11) ? !m_last : req[1];
                m_p        = m_w ? int'(period1) : int'(period0);
                m_t        = cyc;
                m_done_cyc = cyc + (m_w ? int'(count1) : int'(count0)) * (m_p + 1) + 1;
                m_active   = 1'b1;
            end
            cyc++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    typedef struct {
        logic [1:0] req;
        int p0, n0, p1, n1;
        int abort_rel;
        int exp_done;
        int exp_np;
        int exp_first;
        int exp_doff;
    } vec_t;

    // Issue one burst from IDLE, scramble the config inputs after sampling,
    // and measure pulse count, first pulse and done offsets relative to T.
    task automatic run_burst(input vec_t v, output int np, output int first,
                             output int doff, output int dv, output int post);
        np = 0; first = 0; doff = 0; dv = 0; post = 0;
        @(posedge clk); #1;
        req = v.req;
        period0 = v.p0[7:0]; count0 = v.n0[7:0];
        period1 = v.p1[7:0]; count1 = v.n1[7:0];
        abort = 1'b0;
        for (int i = 1; i <= 400 && doff == 0; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                req = 2'b00;
                period0 = 8'($urandom); count0 = 8'($urandom);
                period1 = 8'($urandom); count1 = 8'($urandom);
            end
            abort = (v.abort_rel >= 0 && first > 0 && i == first + v.abort_rel);
            @(negedge clk);
            if (pulse) begin
                np++;
                if (first == 0) first = i;
            end
            if (done != 2'b00) begin
                doff = i;
                dv = int'(done);
            end
        end
        @(posedge clk); #1 abort = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (pulse) post++;
        end
    endtask

    vec_t tbl[7];

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int np, first, doff, dv, post;
        int g1_first, nd;
        int d_off[4];
        int d_own[4];

        tbl[0] = '{2'b01,   4,  3, 0,  0, -1, 1, 3,   5,  16};
        tbl[1] = '{2'b10,   0,  0, 2,  2, -1, 2, 2,   3,   7};
        tbl[2] = '{2'b11,   1,  2, 0,  2, -1, 1, 2,   2,   5};
        tbl[3] = '{2'b01,   0,  4, 0,  0, -1, 1, 4,   1,   5};
        tbl[4] = '{2'b01,   0,  0, 0,  0, -1, 1, 0,   0,   1};
        tbl[5] = '{2'b01, 255,  1, 0,  0, -1, 1, 1, 256, 257};
        tbl[6] = '{2'b10,   0,  0, 3, 10,  2, 2, 1,   4,   7};

        repeat (2) @(posedge clk);
        #1;
        mon_on = 1'b1;
        check("reset_grant", int'(grant), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_pulse", int'(pulse), 0);
        check("reset_done", int'(done), 0);
        reset = 1'b0;

        for (int k = 0; k < 7; k++) begin
            do_reset();
            run_burst(tbl[k], np, first, doff, dv, post);
            check($sformatf("tbl%0d_done_owner", k), dv, tbl[k].exp_done);
            check($sformatf("tbl%0d_pulses", k), np, tbl[k].exp_np);
            check($sformatf("tbl%0d_first_pulse", k), first, tbl[k].exp_first);
            check($sformatf("tbl%0d_done_offset", k), doff, tbl[k].exp_doff);
            check($sformatf("tbl%0d_late_pulses", k), post, 0);
        end

        // Contention with both requests held: alternation and timing.
        do_reset();
        @(posedge clk); #1;
        req = 2'b11; period0 = 8'd1; count0 = 8'd2; period1 = 8'd0; count1 = 8'd2;
        g1_first = -1; nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (grant == 2'b10 && g1_first < 0) g1_first = i;
            if (done != 2'b00 && nd < 4) begin
                d_off[nd] = i;
                d_own[nd] = int'(done);
                nd++;
            end
            @(posedge clk); #1;
        end
        req = 2'b00;
        check("cont_num_done", nd, 4);
        check("cont_grant1_start", g1_first, 7);
        check("cont_done0_offset", d_off[0], 5);
        check("cont_done1_offset", d_off[1], 9);
        for (int j = 0; j < 4; j++)
            check($sformatf("cont_owner%0d", j), d_own[j], (j % 2 == 0) ? 1 : 2);
        repeat (15) @(posedge clk);

        // Mid-burst reset clears outputs and the round-robin pointer.
        do_reset();
        @(posedge clk); #1 req = 2'b01; count0 = 8'd0;
        @(posedge clk); #1 req = 2'b00;
        repeat (3) @(posedge clk);
        #1 req = 2'b10; period1 = 8'd10; count1 = 8'd5;
        @(posedge clk); #1 req = 2'b00;
        @(posedge clk); #1;
        @(negedge clk);
        check("mrst_busy_before", int'(busy), 1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("mrst_grant", int'(grant), 0);
        check("mrst_busy", int'(busy), 0);
        check("mrst_pulse", int'(pulse), 0);
        check("mrst_done", int'(done), 0);
        @(posedge clk); #1 req = 2'b11; period0 = 8'd2; count0 = 8'd1; period1 = 8'd2; count1 = 8'd1;
        @(posedge clk); #1 req = 2'b00;
        @(negedge clk);
        check("mrst_tie_grant", int'(grant), 1);
        repeat (10) @(posedge clk);

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            req     = 2'($urandom_range(0, 3));
            period0 = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
            period1 = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
            count0  = 8'($urandom_range(0, 4));
            count1  = 8'($urandom_range(0, 4));
            abort   = ($urandom_range(0, 19) == 0);
            reset   = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk); #1;
        req = 2'b00; abort = 1'b0; reset = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
